cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 1 (data cache) over port 0 (instruction cache).
REQ-002 The block SHALL have the port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have the port rst_n, input, width 1, the reset; it is synchronous and active-high (asserted = 1 despite the name).
REQ-004 The block SHALL have the port i_sN_addr, input, width 26, the block address from requester N (N = 0, 1).
REQ-005 The block SHALL have the port i_sN_writedata, input, width 128, the write line from requester N.
REQ-006 The block SHALL have the ports i_sN_read and i_sN_write, input, width 1 each, the request strobes from requester N.
REQ-007 The block SHALL have the port o_sN_readdata, output, width 128, read data to requester N.
REQ-008 The block SHALL have the port o_sN_readdata_valid, output, width 1, the read-data strobe to requester N.
REQ-009 The block SHALL have the port o_sN_waitrequest, output, width 1, the stall signal to requester N.
REQ-010 The block SHALL have the ports o_m_addr (26), o_m_writedata (128), o_m_read (1), o_m_write (1) and o_m_byte_en (4), all outputs, forming the memory command port.
REQ-011 The block SHALL have the ports i_m_readdata (128), i_m_readdata_valid (1) and i_m_waitrequest (1), all inputs, forming the memory response port.
REQ-012 The block SHALL have the ports cnt_grant0 and cnt_grant1, output, width 32 each, counting grants per port.

Function
REQ-013 The block SHALL drive o_m_byte_en as constant 4'b1111.
REQ-014 The block SHALL implement FSM states IDLE, CMD and RDWAIT, and SHALL hold a registered grant owner (1 bit) and a last-served bit (1 bit).
REQ-015 In IDLE, if any i_sN_read or i_sN_write is high, the block SHALL register the winner as owner and enter CMD on the next edge; the minimum command latency is 1 cycle.
REQ-016 Winner selection with RR_EN=1: on a single request, that port wins; on simultaneous requests, the port not equal to last-served wins.
REQ-017 Winner selection with RR_EN=0: port 1 SHALL win whenever it requests.
REQ-018 In CMD, o_m_addr, o_m_writedata, o_m_read and o_m_write SHALL combinationally follow the owner's inputs.
REQ-019 In CMD, o_s<owner>_waitrequest SHALL equal i_m_waitrequest.
REQ-020 In CMD, if the owner has both read and write high, the block SHALL forward the read and force o_m_write = 0.
REQ-021 In CMD with i_m_waitrequest=0 and a read forwarded, the block SHALL enter RDWAIT.
REQ-022 In CMD with i_m_waitrequest=0 and a write forwarded, the block SHALL enter IDLE, set last-served to the owner, and increment cnt_grant<owner>.
REQ-023 In CMD, if the owner drops both strobes before acceptance, the block SHALL return to IDLE with no counter or last-served update.
REQ-024 In RDWAIT, o_m_read and o_m_write SHALL be 0.
REQ-025 In RDWAIT, on i_m_readdata_valid=1 the block SHALL assert o_s<owner>_readdata_valid for that same cycle (combinational pass-through), go to IDLE, set last-served, and increment cnt_grant<owner>.
REQ-026 In RDWAIT, i_m_readdata_valid SHALL never be routed to the non-owner.
REQ-027 i_m_readdata SHALL be broadcast to both o_sN_readdata in all states.
REQ-028 In IDLE, RDWAIT, and in CMD for the non-owner, o_sN_waitrequest SHALL be 1.
REQ-029 In IDLE, o_m_read and o_m_write SHALL be 0.
REQ-030 Exactly one transaction SHALL be outstanding at a time; new requests are not arbitrated until the FSM returns to IDLE.
REQ-031 i_m_readdata_valid arriving in IDLE or CMD SHALL be ignored.
REQ-032 The counters SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-033 While rst_n=1 at a clock edge, the block SHALL go to IDLE with owner=0, last-served=1 (so port 0 wins the first tie), and both counters at 0.
REQ-034 Reset asserted mid-transaction SHALL abandon it; any later i_m_readdata_valid SHALL be ignored per REQ-031.
REQ-035 During and after reset, o_m_read=0, o_m_write=0, all o_sN_waitrequest=1 and all o_sN_readdata_valid=0.

Verification
REQ-036 Port 0 read addr 26'h0000040 alone, memory wait 0, valid 3 cycles later -> o_m_read high exactly 1 cycle with o_m_addr=26'h0000040; o_s0_readdata_valid 1 pulse; cnt_grant0=1.
REQ-037 Both ports read continuously from reset with RR_EN=1 -> grants alternate 0,1,0,1; after 4 reads cnt_grant0=2 and cnt_grant1=2; o_s1_readdata_valid never pulses while owner=0.
REQ-038 With RR_EN=0, both ports request -> port 1 served first and repeatedly while it keeps requesting; port 0 waitrequest stays 1.
REQ-039 Port 1 write with i_m_waitrequest held 1 for 5 cycles -> o_m_write held 5+1 cycles with stable addr and data; o_s1_waitrequest mirrors memory; FSM back in IDLE after acceptance; no o_s1_readdata_valid pulse.
REQ-040 Reset asserted in RDWAIT, then i_m_readdata_valid pulses -> no o_sN_readdata_valid pulse; counters 0; next request is served normally.
REQ-041 Counter preloaded via force to 32'hFFFFFFFF, then one grant -> counter reads 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - two-requester cache-to-memory arbiter
// One transaction in flight at a time; read data is broadcast and only the strobe is steered.
module cache_mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [25:0]  i_s0_addr,
  input  logic [127:0] i_s0_writedata,
  input  logic         i_s0_read,
  input  logic         i_s0_write,
  output logic [127:0] o_s0_readdata,
  output logic         o_s0_readdata_valid,
  output logic         o_s0_waitrequest,
  input  logic [25:0]  i_s1_addr,
  input  logic [127:0] i_s1_writedata,
  input  logic         i_s1_read,
  input  logic         i_s1_write,
  output logic [127:0] o_s1_readdata,
  output logic         o_s1_readdata_valid,
  output logic         o_s1_waitrequest,
  output logic [25:0]  o_m_addr,
  output logic [127:0] o_m_writedata,
  output logic         o_m_read,
  output logic         o_m_write,
  output logic [3:0]   o_m_byte_en,
  input  logic [127:0] i_m_readdata,
  input  logic         i_m_readdata_valid,
  input  logic         i_m_waitrequest,
  output logic [31:0]  cnt_grant0,
  output logic [31:0]  cnt_grant1
);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  state_t      state;
  logic        owner;
  logic        last_served;
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  logic s0_req, s1_req, winner;
  logic own_rd, own_wr;
  logic in_cmd, in_rdwait;

  assign s0_req    = i_s0_read | i_s0_write;
  assign s1_req    = i_s1_read | i_s1_write;
  assign own_rd    = owner ? i_s1_read  : i_s0_read;
  assign own_wr    = owner ? i_s1_write : i_s0_write;
  // Gated by reset so the memory port is quiet even before the first reset edge lands.
  assign in_cmd    = (state == CMD)    && !rst_n;
  assign in_rdwait = (state == RDWAIT) && !rst_n;

  always_comb begin
    winner = s1_req;
    if (RR_EN && s0_req && s1_req)
      winner = ~last_served;
  end

  assign o_m_addr      = owner ? i_s1_addr      : i_s0_addr;
  assign o_m_writedata = owner ? i_s1_writedata : i_s0_writedata;
  assign o_m_read      = in_cmd & own_rd;
  assign o_m_write     = in_cmd & own_wr & ~own_rd;
  assign o_m_byte_en   = 4'b1111;

  assign o_s0_waitrequest    = (in_cmd && !owner) ? i_m_waitrequest : 1'b1;
  assign o_s1_waitrequest    = (in_cmd &&  owner) ? i_m_waitrequest : 1'b1;
  assign o_s0_readdata_valid = in_rdwait & ~owner & i_m_readdata_valid;
  assign o_s1_readdata_valid = in_rdwait &  owner & i_m_readdata_valid;
  assign o_s0_readdata       = i_m_readdata;
  assign o_s1_readdata       = i_m_readdata;

  assign cnt_grant0 = cnt0_q;
  assign cnt_grant1 = cnt1_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      cnt0_q      <= 32'd0;
      cnt1_q      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_req || s1_req) begin
            owner <= winner;
            state <= CMD;
          end
        end
        CMD: begin
          if (!(own_rd || own_wr)) begin
            state <= IDLE;
          end else if (!i_m_waitrequest) begin
            if (own_rd) begin
              state <= RDWAIT;
            end else begin
              state       <= IDLE;
              last_served <= owner;
              if (owner) cnt1_q <= cnt1_q + 32'd1;
              else       cnt0_q <= cnt0_q + 32'd1;
            end
          end
        end
        RDWAIT: begin
          if (i_m_readdata_valid) begin
            state       <= IDLE;
            last_served <= owner;
            if (owner) cnt1_q <= cnt1_q + 32'd1;
            else       cnt0_q <= cnt0_q + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed bench for cache_mem_arbiter
// Round-robin instance driven from a vector table; a fixed-priority instance shares the stimulus.
module tb_cache_mem_arbiter;

  localparam logic [25:0]  A0 = 26'h0000040;
  localparam logic [25:0]  A1 = 26'h0000080;
  localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D1 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567;
  localparam logic [127:0] RD = 128'h5A5A_0000_C3C3_1234_FFFF_0000_8765_4321;

  logic clk = 1'b0;
  logic rst_n;
  logic [25:0]  s0_addr, s1_addr;
  logic [127:0] s0_wd, s1_wd, m_rdata;
  logic s0_rd, s0_wr, s1_rd, s1_wr, m_valid, m_wait;

  logic [127:0] s0_rdata, s1_rdata, m_wd, f_s0_rdata, f_s1_rdata, f_m_wd;
  logic s0_v, s1_v, s0_w, s1_w, m_rd, m_wr;
  logic f_s0_v, f_s1_v, f_s0_w, f_s1_w, f_m_rd, f_m_wr;
  logic [25:0] m_addr, f_m_addr;
  logic [3:0]  m_be, f_m_be;
  logic [31:0] c0, c1, f_c0, f_c1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s0_addr(s0_addr), .i_s0_writedata(s0_wd), .i_s0_read(s0_rd), .i_s0_write(s0_wr),
    .o_s0_readdata(s0_rdata), .o_s0_readdata_valid(s0_v), .o_s0_waitrequest(s0_w),
    .i_s1_addr(s1_addr), .i_s1_writedata(s1_wd), .i_s1_read(s1_rd), .i_s1_write(s1_wr),
    .o_s1_readdata(s1_rdata), .o_s1_readdata_valid(s1_v), .o_s1_waitrequest(s1_w),
    .o_m_addr(m_addr), .o_m_writedata(m_wd), .o_m_read(m_rd), .o_m_write(m_wr),
    .o_m_byte_en(m_be), .i_m_readdata(m_rdata), .i_m_readdata_valid(m_valid),
    .i_m_waitrequest(m_wait), .cnt_grant0(c0), .cnt_grant1(c1)
  );

  cache_mem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_s0_addr(s0_addr), .i_s0_writedata(s0_wd), .i_s0_read(s0_rd), .i_s0_write(s0_wr),
    .o_s0_readdata(f_s0_rdata), .o_s0_readdata_valid(f_s0_v), .o_s0_waitrequest(f_s0_w),
    .i_s1_addr(s1_addr), .i_s1_writedata(s1_wd), .i_s1_read(s1_rd), .i_s1_write(s1_wr),
    .o_s1_readdata(f_s1_rdata), .o_s1_readdata_valid(f_s1_v), .o_s1_waitrequest(f_s1_w),
    .o_m_addr(f_m_addr), .o_m_writedata(f_m_wd), .o_m_read(f_m_rd), .o_m_write(f_m_wr),
    .o_m_byte_en(f_m_be), .i_m_readdata(m_rdata), .i_m_readdata_valid(m_valid),
    .i_m_waitrequest(m_wait), .cnt_grant0(f_c0), .cnt_grant1(f_c1)
  );

  // stim = {s0_rd, s0_wr, s1_rd, s1_wr, m_wait, m_valid}
  // exp  = {m_rd, m_wr, m_addr, s0_w, s1_w, s0_v, s1_v}; addr only checked when a strobe is expected
  typedef struct {
    logic [5:0]  stim;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] stim, input logic rd, input logic wr, input logic [25:0] a,
                     input logic [3:0] wv, input string name);
    vec_t v;
    v.stim = stim;
    v.exp  = {rd, wr, a, wv};
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    s0_rd = 0; s0_wr = 0; s1_rd = 0; s1_wr = 0; m_wait = 0; m_valid = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
  endtask

  logic [31:0] got;
  int wr_cycles;
  logic seen_v;

  initial begin
    s0_addr = A0; s1_addr = A1; s0_wd = D0; s1_wd = D1; m_rdata = RD;
    @(negedge clk);
    do_reset();

    #1;
    chk("reset_cnt0", c0, 0);
    chk("reset_cnt1", c1, 0);
    chk("reset_wait", {s0_w, s1_w, m_rd, m_wr}, 4'b1100);
    chk("byte_en", m_be, 4'hF);
    chk("rdata_bcast0", s0_rdata, RD);
    chk("rdata_bcast1", s1_rdata, RD);

    add(6'b100000, 0, 0, 0,  4'b1100, "p0_idle");
    add(6'b100000, 1, 0, A0, 4'b0100, "p0_cmd");
    add(6'b000000, 0, 0, 0,  4'b1100, "p0_rdw1");
    add(6'b000000, 0, 0, 0,  4'b1100, "p0_rdw2");
    add(6'b000001, 0, 0, 0,  4'b1110, "p0_valid");
    add(6'b101000, 0, 0, 0,  4'b1100, "rr_idle1");
    add(6'b101000, 1, 0, A1, 4'b1000, "rr_cmd1");
    add(6'b101001, 0, 0, 0,  4'b1101, "rr_valid1");
    add(6'b101000, 0, 0, 0,  4'b1100, "rr_idle0");
    add(6'b101000, 1, 0, A0, 4'b0100, "rr_cmd0");
    add(6'b101001, 0, 0, 0,  4'b1110, "rr_valid0");
    add(6'b101000, 0, 0, 0,  4'b1100, "rr_idle1b");
    add(6'b101000, 1, 0, A1, 4'b1000, "rr_cmd1b");
    add(6'b101001, 0, 0, 0,  4'b1101, "rr_valid1b");
    add(6'b110010, 0, 0, 0,  4'b1100, "rw_idle");
    add(6'b110011, 1, 0, A0, 4'b1100, "rw_cmd_rdwins");
    add(6'b000000, 0, 0, 0,  4'b0100, "rw_drop");
    add(6'b000001, 0, 0, 0,  4'b1100, "idle_valid_ign");

    foreach (vecs[i]) begin
      {s0_rd, s0_wr, s1_rd, s1_wr, m_wait, m_valid} = vecs[i].stim;
      #1;
      got = {m_rd, m_wr, (vecs[i].exp[31] | vecs[i].exp[30]) ? m_addr : vecs[i].exp[29:4],
             s0_w, s1_w, s0_v, s1_v};
      chk(vecs[i].name, got, vecs[i].exp);
      cyc();
    end
    chk("rr_cnt0", c0, 2);
    chk("rr_cnt1", c1, 2);

    // port 1 write held off by memory for 5 cycles
    do_reset();
    s1_wr = 1; m_wait = 1;
    cyc();
    wr_cycles = 0;
    seen_v = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) m_wait = 0;
      #1;
      if (m_wr) wr_cycles++;
      seen_v |= s1_v;
      chk("wr_addr", m_addr, A1);
      chk("wr_data", m_wd, D1);
      chk("wr_s1_wait", s1_w, m_wait);
      cyc();
    end
    s1_wr = 0;
    #1;
    seen_v |= s1_v;
    chk("wr_cycles", wr_cycles, 6);
    chk("wr_done_idle", {m_wr, s1_w}, 2'b01);
    chk("wr_cnt1", c1, 1);
    chk("wr_no_valid", seen_v, 0);

    // fixed priority: port 1 keeps winning
    do_reset();
    s0_rd = 1; s1_wr = 1;
    seen_v = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      seen_v |= ~f_s0_w;
      cyc();
    end
    chk("fp_s0_stalled", seen_v, 0);
    chk("fp_cnt1", f_c1, 3);
    chk("fp_cnt0", f_c0, 0);

    // reset in RDWAIT abandons the read
    do_reset();
    s0_rd = 1;
    cyc();
    cyc();
    s0_rd = 0;
    rst_n = 1'b1;
    cyc();
    m_valid = 1;
    #1;
    chk("in_reset_outs", {m_rd, m_wr, s0_w, s1_w, s0_v, s1_v}, 6'b001100);
    rst_n = 1'b0;
    seen_v = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      seen_v |= s0_v | s1_v;
      cyc();
    end
    chk("rst_no_valid", seen_v, 0);
    chk("rst_cnts", {c0, c1}, 64'd0);
    m_valid = 0; s1_rd = 1;
    cyc();
    #1;
    chk("post_rst_cmd", {m_rd, m_addr}, {1'b1, A1});
    cyc();
    s1_rd = 0; m_valid = 1;
    #1;
    chk("post_rst_valid", {s0_v, s1_v}, 2'b01);
    cyc();
    m_valid = 0;
    chk("post_rst_cnt1", c1, 1);

    // counter wrap
    do_reset();
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0_q;
    chk("preload", c0, 32'hFFFF_FFFF);
    s0_wr = 1;
    cyc();
    cyc();
    s0_wr = 0;
    #1;
    chk("cnt_wrap", c0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
